// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand bypass and load-use hazard detection.
// Optional feature macro: FORWARDING_EN (EX/MEM and MEM/WB operand bypass).
`default_nettype none

module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_id_valid,
    input  logic [31:0] i_id_rs_data,
    input  logic [31:0] i_id_rt_data,
    input  logic [31:0] i_id_imm,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic [4:0]  i_id_rd,
    input  logic [3:0]  i_id_alu_op,
    input  logic [4:0]  i_id_shamt,
    input  logic        i_id_alu_src,
    input  logic        i_id_reg_write,
    input  logic        i_id_mem_read,
    input  logic        i_id_mem_write,
    input  logic        i_id_mem_to_reg,

    input  logic        i_stall,
    input  logic        i_flush,

    input  logic        i_exmem_reg_write,
    input  logic [4:0]  i_exmem_rd,
    input  logic [31:0] i_exmem_result,
    input  logic        i_memwb_reg_write,
    input  logic [4:0]  i_memwb_rd,
    input  logic [31:0] i_memwb_result,

    output logic [31:0] o_op1,
    output logic [31:0] o_op2,
    output logic [3:0]  o_operation,
    output logic [4:0]  o_shamt,

    output logic        o_ex_valid,
    output logic [4:0]  o_ex_rd,
    output logic [31:0] o_ex_store_data,
    output logic        o_ex_reg_write,
    output logic        o_ex_mem_read,
    output logic        o_ex_mem_write,
    output logic        o_ex_mem_to_reg,

    output logic        o_load_use_stall
);

    logic        r_valid;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [3:0]  r_alu_op;
    logic [4:0]  r_shamt;
    logic        r_alu_src;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_mem_to_reg;

    // Flush outranks stall so a squashed instruction can never be held in EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_rs_data    <= 32'd0;
            r_rt_data    <= 32'd0;
            r_imm        <= 32'd0;
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
            r_alu_op     <= 4'h0;
            r_shamt      <= 5'd0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (i_flush) begin
            r_valid      <= 1'b0;
            r_rs_data    <= 32'd0;
            r_rt_data    <= 32'd0;
            r_imm        <= 32'd0;
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
            r_alu_op     <= 4'h0;
            r_shamt      <= 5'd0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (!i_stall) begin
            r_valid      <= i_id_valid;
            r_rs_data    <= i_id_rs_data;
            r_rt_data    <= i_id_rt_data;
            r_imm        <= i_id_imm;
            r_rs         <= i_id_rs;
            r_rt         <= i_id_rt;
            r_rd         <= i_id_rd;
            r_alu_op     <= i_id_alu_op;
            r_shamt      <= i_id_shamt;
            r_alu_src    <= i_id_alu_src;
            r_reg_write  <= i_id_reg_write;
            r_mem_read   <= i_id_mem_read;
            r_mem_write  <= i_id_mem_write;
            r_mem_to_reg <= i_id_mem_to_reg;
        end
    end

    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_load_use;

`ifdef FORWARDING_EN
    // Youngest producer (EX/MEM) wins; r0 and bubbles are never bypassed.
    always_comb begin
        w_rs_val = r_rs_data;
        if (r_valid && (r_rs != 5'd0)) begin
            if (i_exmem_reg_write && (i_exmem_rd == r_rs))
                w_rs_val = i_exmem_result;
            else if (i_memwb_reg_write && (i_memwb_rd == r_rs))
                w_rs_val = i_memwb_result;
        end
    end

    always_comb begin
        w_rt_val = r_rt_data;
        if (r_valid && (r_rt != 5'd0)) begin
            if (i_exmem_reg_write && (i_exmem_rd == r_rt))
                w_rt_val = i_exmem_result;
            else if (i_memwb_reg_write && (i_memwb_rd == r_rt))
                w_rt_val = i_memwb_result;
        end
    end

    // Only a load in EX cannot be bypassed in time; everything else forwards.
    assign w_load_use = i_id_valid && r_valid && r_mem_read && (r_rd != 5'd0) &&
                        ((r_rd == i_id_rs) || (r_rd == i_id_rt));
`else
    assign w_rs_val = r_rs_data;
    assign w_rt_val = r_rt_data;

    // Without bypass any in-flight writer of a source register must stall decode.
    assign w_load_use = i_id_valid && (
        (r_valid && r_reg_write && (r_rd != 5'd0) &&
         ((r_rd == i_id_rs) || (r_rd == i_id_rt))) ||
        (i_exmem_reg_write && (i_exmem_rd != 5'd0) &&
         ((i_exmem_rd == i_id_rs) || (i_exmem_rd == i_id_rt))));

    logic w_unused;
    assign w_unused = ^{i_exmem_result, i_memwb_reg_write, i_memwb_rd,
                        i_memwb_result, r_rs, r_rt};
`endif

    assign o_op1            = w_rs_val;
    assign o_op2            = r_alu_src ? r_imm : w_rt_val;
    assign o_operation      = r_alu_op;
    assign o_shamt          = r_shamt;
    assign o_ex_valid       = r_valid;
    assign o_ex_rd          = r_rd;
    assign o_ex_store_data  = w_rt_val;
    assign o_ex_reg_write   = r_reg_write;
    assign o_ex_mem_read    = r_mem_read;
    assign o_ex_mem_write   = r_mem_write;
    assign o_ex_mem_to_reg  = r_mem_to_reg;
    assign o_load_use_stall = w_load_use;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; expected EX state queued at drive time.
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic [3:0]  id_alu_op = '0;
    logic [4:0]  id_shamt = '0;
    logic        id_alu_src = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic        id_mem_write = 1'b0, id_mem_to_reg = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        exmem_rw = 1'b0, memwb_rw = 1'b0;
    logic [4:0]  exmem_rd = '0, memwb_rd = '0;
    logic [31:0] exmem_res = '0, memwb_res = '0;

    logic [31:0] op1, op2, store_data;
    logic [3:0]  operation;
    logic [4:0]  shamt, ex_rd;
    logic        ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, lus;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .i_id_valid(id_valid), .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data),
        .i_id_imm(id_imm), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd),
        .i_id_alu_op(id_alu_op), .i_id_shamt(id_shamt), .i_id_alu_src(id_alu_src),
        .i_id_reg_write(id_reg_write), .i_id_mem_read(id_mem_read),
        .i_id_mem_write(id_mem_write), .i_id_mem_to_reg(id_mem_to_reg),
        .i_stall(stall), .i_flush(flush),
        .i_exmem_reg_write(exmem_rw), .i_exmem_rd(exmem_rd), .i_exmem_result(exmem_res),
        .i_memwb_reg_write(memwb_rw), .i_memwb_rd(memwb_rd), .i_memwb_result(memwb_res),
        .o_op1(op1), .o_op2(op2), .o_operation(operation), .o_shamt(shamt),
        .o_ex_valid(ex_valid), .o_ex_rd(ex_rd), .o_ex_store_data(store_data),
        .o_ex_reg_write(ex_rw), .o_ex_mem_read(ex_mr), .o_ex_mem_write(ex_mw),
        .o_ex_mem_to_reg(ex_m2r), .o_load_use_stall(lus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] rs_d, rt_d, imm;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic        src, rw, mr, mw, m2r;
    } ex_t;

    ex_t m;
    ex_t sb_q[$];
    int  n_run = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] d);
`ifdef FORWARDING_EN
        if (m.v && src != 5'd0) begin
            if (exmem_rw && exmem_rd == src) return exmem_res;
            if (memwb_rw && memwb_rd == src) return memwb_res;
        end
`endif
        return d;
    endfunction

    function automatic logic exp_lus();
        logic hit_ex, hit_mem;
        hit_ex  = (m.rd != 5'd0) && (m.rd == id_rs || m.rd == id_rt);
        hit_mem = (exmem_rd != 5'd0) && (exmem_rd == id_rs || exmem_rd == id_rt);
`ifdef FORWARDING_EN
        return id_valid && m.v && m.mr && hit_ex;
`else
        return id_valid && ((m.v && m.rw && hit_ex) || (exmem_rw && hit_mem));
`endif
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] rt_v;
        rt_v = fwd(m.rt, m.rt_d);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
        chk({tag, ".rd"}, 32'(ex_rd), 32'(m.rd));
        chk({tag, ".operation"}, 32'(operation), 32'(m.op));
        chk({tag, ".shamt"}, 32'(shamt), 32'(m.sh));
        chk({tag, ".ctrl"}, 32'({ex_rw, ex_mr, ex_mw, ex_m2r}), 32'({m.rw, m.mr, m.mw, m.m2r}));
        chk({tag, ".op1"}, op1, fwd(m.rs, m.rs_d));
        chk({tag, ".op2"}, op2, m.src ? m.imm : rt_v);
        chk({tag, ".store"}, store_data, rt_v);
        chk({tag, ".lus"}, 32'(lus), 32'(exp_lus()));
    endtask

    // Compute what EX must hold after the coming edge, queue it, then compare once it lands.
    task automatic step(input string tag);
        ex_t nx;
        if (flush)      nx = '0;
        else if (stall) nx = m;
        else nx = '{id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
                    id_alu_op, id_shamt, id_alu_src, id_reg_write, id_mem_read,
                    id_mem_write, id_mem_to_reg};
        sb_q.push_back(nx);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_run++; n_fail++;
            $display("FAIL %s.queue: got empty expected entry", tag);
        end else begin
            m = sb_q.pop_front();
            check_all(tag);
        end
    endtask

    task automatic comb_check(input string tag);
        #1;
        check_all(tag);
    endtask

    task automatic set_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [3:0] op, input logic src,
                          input logic rw, input logic mr);
        id_valid = v; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_alu_op = op; id_alu_src = src;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0; id_mem_to_reg = mr;
        id_shamt = 5'd0;
    endtask

    task automatic clear_fwd();
        exmem_rw = 0; exmem_rd = 0; exmem_res = 0;
        memwb_rw = 0; memwb_rd = 0; memwb_res = 0;
    endtask

    initial begin
        m = '0;
        repeat (2) @(posedge clk);
        #2;
        comb_check("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain capture with immediate operand
        set_id(1, 32'd5, 32'd7, 32'h10, 5'd1, 5'd2, 5'd9, 4'h4, 1, 1, 0);
        step("capture");

        // Double forward: EX/MEM outranks MEM/WB, then MEM/WB alone
        set_id(1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd6, 5'd10, 4'h2, 0, 1, 0);
        exmem_rw = 1; exmem_rd = 5'd3; exmem_res = 32'hAA;
        memwb_rw = 1; memwb_rd = 5'd3; memwb_res = 32'hBB;
        step("dfwd");
        exmem_rw = 0;
        comb_check("dfwd_memwb");
        clear_fwd();

        // Register 0 is never bypassed
        set_id(1, 32'h1, 32'h3344, 32'h55, 5'd0, 5'd0, 5'd11, 4'h1, 0, 1, 0);
        exmem_rw = 1; exmem_rd = 5'd0; exmem_res = 32'hFF;
        step("reg0");
        clear_fwd();

        // Load-use: lw r8 in EX, dependent instruction in ID
        set_id(1, 32'h100, 32'h0, 32'h4, 5'd2, 5'd0, 5'd8, 4'h0, 1, 1, 1);
        step("lw");
        set_id(1, 32'h77, 32'h66, 32'h0, 5'd8, 5'd5, 5'd12, 4'h3, 0, 1, 0);
        comb_check("lu_detect");
        stall = 1;
        step("lu_hold");
        flush = 1;
        step("lu_flush_and_stall");
        stall = 0;
        step("lu_flush");
        flush = 0;

        // Writer in EX with rd=4, consumer reads rt=4; EX/MEM carries a different value
        set_id(1, 32'h9, 32'h8, 32'h0, 5'd1, 5'd2, 5'd4, 4'h5, 0, 1, 0);
        step("w4");
        set_id(1, 32'hA, 32'hB, 32'h0, 5'd7, 5'd4, 5'd13, 4'h6, 0, 1, 0);
        exmem_rw = 1; exmem_rd = 5'd4; exmem_res = 32'hDEAD;
        comb_check("w4_detect");
        step("w4_next");
        clear_fwd();

        // Reset while stalled discards the held instruction
        set_id(1, 32'h123, 32'h456, 32'h789, 5'd1, 5'd2, 5'd3, 4'h7, 1, 1, 0);
        step("pre_rst");
        stall = 1;
        step("pre_rst_hold");
        #3;
        rst_n = 1'b0;
        m = '0;
        sb_q.delete();
        comb_check("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        stall = 0;
        set_id(1, 32'h321, 32'h654, 32'h987, 5'd2, 5'd1, 5'd5, 4'h9, 0, 1, 0);
        step("post_rst");

        // Random traffic over a small register window to hit overlaps often
        for (int i = 0; i < 60; i++) begin
            set_id(1'($urandom), $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 4'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            id_shamt = 5'($urandom);
            id_mem_write = 1'($urandom);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 5) == 0);
            exmem_rw = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_res = $urandom;
            memwb_rw = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_res = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-002 SHALL have decode inputs: id_valid 1; id_rs_data/id_rt_data/id_imm 32 (imm already extended); id_rs/id_rt/id_rd 5; id_alu_op 4; id_shamt 5; id_alu_src 1; id_reg_write/id_mem_read/id_mem_write/id_mem_to_reg 1.
REQ-003 SHALL have control inputs: stall in 1 hold stage; flush in 1 insert bubble.
REQ-004 SHALL have forwarding inputs: exmem_reg_write 1, exmem_rd 5, exmem_result 32, memwb_reg_write 1, memwb_rd 5, memwb_result 32.
REQ-005 SHALL have ALU-facing outputs: Op1 32, Op2 32, operation 4, shamt 5.
REQ-006 SHALL have pass-down outputs: ex_valid 1, ex_rd 5, ex_store_data 32, ex_reg_write/ex_mem_read/ex_mem_write/ex_mem_to_reg 1.
REQ-007 SHALL have hazard output: load_use_stall 1, combinational, to fetch/decode.

Function
REQ-008 SHALL register all decode inputs on posedge clk; one-cycle latency ID->EX.
REQ-009 flush=1 at edge: SHALL load bubble (ex_valid=0, all ex_* controls 0, operation=4'h0, data fields 0).
REQ-010 stall=1, flush=0: SHALL hold every register unchanged.
REQ-011 flush and stall together: flush SHALL win.
REQ-012 Op1 SHALL = forwarded rs value; Op2 SHALL = registered imm if alu_src=1, else forwarded rt value.
REQ-013 ex_store_data SHALL = forwarded rt value regardless of alu_src.
REQ-014 Forwarding per operand: match on exmem_reg_write & exmem_rd==src & src!=0 -> exmem_result; else match on memwb -> memwb_result; else registered data.
REQ-015 EX/MEM match SHALL take priority over MEM/WB when both match.
REQ-016 Register 0 SHALL never be forwarded; Op sourced from reg 0 SHALL be the registered value.
REQ-017 operation and shamt SHALL be the registered id_alu_op and id_shamt, unchanged.
REQ-018 load_use_stall SHALL = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt) & id_valid.
REQ-019 Bubble (ex_valid=0) SHALL never cause forwarding or stall assertion.

Reset
REQ-020 rst_n low SHALL asynchronously clear every register to 0 (ex_valid=0, operation=0, controls 0).
REQ-021 Reset mid-stall SHALL discard held instruction; first edge after release captures decode inputs normally.
REQ-022 During reset, Op1/Op2 SHALL equal 0 unless forwarding inputs match (reg fields are 0, so no match).

Configuration
REQ-023 Macro FORWARDING_EN SHALL select operand bypass.
REQ-024 Defined: REQ-014..016 and REQ-018 apply.
REQ-025 Undefined: no bypass, Op1/Op2/ex_store_data from registered data only; load_use_stall SHALL assert for any nonzero id_rs/id_rt match against ex_rd (ex_valid & ex_reg_write) or exmem_rd (exmem_reg_write).

Verification
REQ-026 Reset: rst_n=0 mid-cycle -> all outputs 0 immediately, ex_valid=0.
REQ-027 Plain capture: id_rs_data=5, id_imm=0x10, id_alu_src=1, id_alu_op=4'h4 -> next cycle Op1=5, Op2=0x10, operation=4.
REQ-028 Double forward: id_rs=3; exmem_rd=3/result=0xAA; memwb_rd=3/result=0xBB -> Op1=0xAA; drop exmem_reg_write -> Op1=0xBB.
REQ-029 Reg 0: id_rt=0, exmem_rd=0, exmem_reg_write=1, result=0xFF, alu_src=0 -> Op2=registered rt data.
REQ-030 Load-use: EX holds lw to r8 (mem_read=1); id_rs=8 -> load_use_stall=1; stall=1 holds; flush=1 -> ex_valid=0, controls 0.
REQ-031 Without FORWARDING_EN: ex_rd=4 reg_write=1, id_rt=4 -> load_use_stall=1, Op2 ignores exmem_result.
